light_timer: RTL and testbench
==============================

// Module: light_timer
// PURPOSE
//  Timing stage directly upstream of Light_FSM.
//  - Divides clk into one-second periods.
//  - Counts down the seconds left in the current light phase.
//  - Drives second_cnt_pre_last and light_cnt_last, which Light_FSM uses to advance.
//  - Reloads the phase counter from Light_FSM's light_cnt_init at each phase end.
//  - Exposes the remaining-seconds count for a countdown display.
// PARAMETERS
//  CLK_PER_SEC        default 10  clk cycles per second; legal range >= 2 (50_000_000 on board)
//  LIGHT_CNT_WIDTH    default 3   width of light_cnt_init and light_cnt
// PORTS
//  clk                  in   1    system clock, rising edge
//  rst_n                in   1    asynchronous active-low reset
//  en                   in   1    count enable; when low, all counters hold
//  clr                  in   1    synchronous restart; overrides en
//  light_cnt_init       in   W    phase length minus 1 (seconds), from Light_FSM
//  second_cnt_pre_last  out  1    second counter == CLK_PER_SEC-2, and en
//  second_cnt_last      out  1    second counter == CLK_PER_SEC-1, and en (1-cycle tick)
//  light_cnt_last       out  1    light_cnt == 0, regardless of en (last second of phase)
//  light_cnt            out  W    seconds remaining in phase, minus 1
// BEHAVIOUR
//  Reset (async, rst_n=0)
//  - sec_cnt=0, light_cnt=0.
//  - All outputs reset: light_cnt_last=1, second_cnt_pre_last=0, second_cnt_last=0.
//  - Light_FSM's reset state therefore lasts exactly one second after en rises.
//  Priority each clk: clr > en > hold.
//  - clr=1: sec_cnt<=0 and light_cnt<=0 (same as reset, but synchronous).
//  - en=0, clr=0: sec_cnt and light_cnt hold; qualified strobes stay 0.
//  - en=1: sec_cnt increments, wrapping CLK_PER_SEC-1 -> 0.
//  Second-counter width: $clog2(CLK_PER_SEC); compare against constants, no truncation.
//  Phase counter updates only on the second wrap (sec_cnt==CLK_PER_SEC-1 and en):
//  - light_cnt==0: light_cnt <= light_cnt_init (reload).
//  - otherwise: light_cnt <= light_cnt-1.
//  Handshake with Light_FSM:
//  - FSM samples light_cnt_last & second_cnt_pre_last at the pre-last edge and changes state.
//  - The FSM's new light_cnt_init is then stable one cycle before the wrap edge that loads it.
//  - So the reload always picks up the init of the NEW state.
//  Phase length = light_cnt_init+1 seconds. light_cnt_init=0 gives a 1-second phase,
//  with light_cnt_last held high continuously.
//  light_cnt_last is combinational from light_cnt only; it is high for the whole last second.
//  CLK_PER_SEC=2: pre_last at sec_cnt=0 and last at sec_cnt=1, alternating every cycle.
//  en drops mid-second: counters freeze, strobes drop. On en re-rise the second resumes
//  from the frozen count; no period is lost or extended beyond the held cycles.
//  clr or reset mid-phase: both counters restart immediately.
//  Strobes: no strobe in the clr cycle; first pre_last comes CLK_PER_SEC-2 enabled cycles later.
//  No combinational path from light_cnt_init to any output.
// STRUCTURE
//  light_pkg (shared with Light_FSM and the top level):
//  - LIGHT_STATE_WIDTH=3.
//  - Light encodings RED=3'b100, YELLOW=3'b010, GREEN=3'b001.
//  - Default phase lengths RED_INIT, YELLOW_INIT, GREEN_INIT.
//  Sub-module mod_counter #(MOD), instanced once for the second prescaler:
//  - ports clk, rst_n, clr, en; outputs cnt, pre_last, last.
//  The phase down-counter is written inline.
// TESTING (CLK_PER_SEC=4, W=3, bench models Light_FSM or instances it)
//  1 Reset, en=1, init=2, 20 cycles:
//    pre_last at sec_cnt=2 every 4 cycles. light_cnt follows 0 -> 2 -> 1 -> 0 -> 2.
//    light_cnt_last is high for 4 cycles in every 12.
//  2 Reload pickup: init changes 2 -> 5 one cycle after pre_last while light_cnt==0:
//    light_cnt loads 5 at the following wrap, not 2.
//  3 en=0 for 3 cycles at sec_cnt=1:
//    sec_cnt and light_cnt hold, strobes stay 0.
//    After en returns, the next pre_last comes exactly 1 enabled cycle later.
//  4 clr pulse while light_cnt=3, sec_cnt=2, en=1:
//    next cycle sec_cnt=0, light_cnt=0, light_cnt_last=1, no pre_last that cycle.
//  5 rst_n pulse low asynchronously between edges:
//    outputs reach reset values immediately, without waiting for a clk edge.
//  6 Closed loop with Light_FSM, init RED=4, YELLOW=1, GREEN=3:
//    lights held 5, 2 and 4 seconds (20, 8 and 16 cycles), cycling R -> G -> Y -> R.

Source files
------------

// File: rtl/light_timer_pkg.sv
// light_pkg: light encodings and default phase lengths shared by the timer, the FSM and the top level.
package light_pkg;
  localparam int LIGHT_STATE_WIDTH = 3;
  typedef enum logic [LIGHT_STATE_WIDTH-1:0] {
    GREEN  = 3'b001,
    YELLOW = 3'b010,
    RED    = 3'b100
  } light_t;
  localparam logic [2:0] RED_INIT    = 3'd4;
  localparam logic [2:0] YELLOW_INIT = 3'd1;
  localparam logic [2:0] GREEN_INIT  = 3'd3;
  function automatic logic [2:0] init_of(light_t s);
    return s == RED ? RED_INIT : s == YELLOW ? YELLOW_INIT : GREEN_INIT;
  endfunction
endpackage

// File: rtl/light_timer_if.sv
// light_timer_if: control inputs and timing strobes between light_timer and Light_FSM.
interface light_timer_if #(
  parameter int W           = 3,
  parameter int CLK_PER_SEC = 10
);
  logic                           en;
  logic                           clr;
  logic [W-1:0]                   light_cnt_init;
  logic                           second_cnt_pre_last;
  logic                           second_cnt_last;
  logic                           light_cnt_last;
  logic [W-1:0]                   light_cnt;
  logic [$clog2(CLK_PER_SEC)-1:0] sec_cnt;
  modport master (
    output en, clr, light_cnt_init,
    input  second_cnt_pre_last, second_cnt_last, light_cnt_last, light_cnt, sec_cnt
  );
  modport slave (
    input  en, clr, light_cnt_init,
    output second_cnt_pre_last, second_cnt_last, light_cnt_last, light_cnt, sec_cnt
  );
endinterface

// File: rtl/light_timer_mod_counter.sv
// mod_counter: modulo-MOD up-counter with enable-qualified pre-last and last strobes.
module mod_counter #(
  parameter int MOD = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  output logic [$clog2(MOD)-1:0] cnt,
  output logic                   pre_last,
  output logic                   last
);
  localparam int CW = $clog2(MOD);
  localparam logic [CW-1:0] LAST = CW'(MOD - 1);
  localparam logic [CW-1:0] PRE  = CW'(MOD - 2);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt == LAST ? '0 : cnt + 1'b1;
  // a restart cycle never strobes, so the FSM cannot advance on a clr
  assign pre_last = en && !clr && cnt == PRE;
  assign last     = en && !clr && cnt == LAST;
endmodule

// File: rtl/light_timer.sv
// light_timer: one-second prescaler plus phase down-counter feeding Light_FSM.
module light_timer
  import light_pkg::*;
#(
  parameter int CLK_PER_SEC     = 10,
  parameter int LIGHT_CNT_WIDTH = 3
) (
  input logic          clk,
  input logic          rst_n,
  light_timer_if.slave bus
);
  logic                       sec_last;
  logic [LIGHT_CNT_WIDTH-1:0] light_cnt;
  mod_counter #(.MOD(CLK_PER_SEC)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.clr),
    .en       (bus.en),
    .cnt      (bus.sec_cnt),
    .pre_last (bus.second_cnt_pre_last),
    .last     (sec_last)
  );
  // reload on the wrap after the FSM has already switched to its new state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) light_cnt <= '0;
    else if (bus.clr) light_cnt <= '0;
    else if (sec_last) light_cnt <= light_cnt == '0 ? bus.light_cnt_init : light_cnt - 1'b1;
  assign bus.light_cnt       = light_cnt;
  assign bus.light_cnt_last  = light_cnt == '0;
  assign bus.second_cnt_last = sec_last;
endmodule

// File: tb/tb_light_timer.sv
// tb_light_timer: directed and random stimulus against a seconds/phase reference model and a Light_FSM model.
module tb_light_timer;
  import light_pkg::*;
  localparam int CPS = 4;
  logic       clk = 1'b0;
  logic       rst_n;
  int         checks = 0;
  int         failures = 0;
  int         m_sec, m_lc, n_pre, n_lcl, hold_lc, run_len;
  logic       o_pre, o_last, o_lcl;
  logic [2:0] fsm_st, run_st;
  int         q_len[$];
  logic [2:0] q_st[$];
  logic [2:0] st_exp[6] = '{RED, GREEN, YELLOW, RED, GREEN, YELLOW};
  int         len_exp[6] = '{20, 16, 8, 20, 16, 8};

  light_timer_if #(.W(3), .CLK_PER_SEC(CPS)) bus ();
  light_timer #(.CLK_PER_SEC(CPS), .LIGHT_CNT_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] fsm_next(input logic [2:0] s);
    return s == RED ? GREEN : s == GREEN ? YELLOW : RED;
  endfunction

  function automatic logic [2:0] fsm_init(input logic [2:0] s);
    return s == 3'b000 ? 3'd0 : init_of(light_t'(s));
  endfunction

  // one clock: drive, check at the falling edge, then advance the models past the rising edge
  task automatic step(input logic e, input logic c, input logic [2:0] ini);
    bus.en = e;
    bus.clr = c;
    bus.light_cnt_init = ini;
    @(negedge clk);
    o_pre  = bus.second_cnt_pre_last;
    o_last = bus.second_cnt_last;
    o_lcl  = bus.light_cnt_last;
    chk("pre_last", o_pre, int'(e && !c && m_sec == CPS - 2));
    chk("sec_last", o_last, int'(e && !c && m_sec == CPS - 1));
    chk("light_cnt_last", o_lcl, int'(m_lc == 0));
    chk("light_cnt", bus.light_cnt, m_lc);
    chk("sec_cnt", bus.sec_cnt, m_sec);
    @(posedge clk);
    if (o_pre && o_lcl) fsm_st = fsm_next(fsm_st);
    if (c) begin
      m_sec = 0;
      m_lc = 0;
    end else if (e) begin
      if (m_sec == CPS - 1) m_lc = m_lc == 0 ? int'(ini) : m_lc - 1;
      m_sec = (m_sec + 1) % CPS;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.clr = 1'b0;
    bus.light_cnt_init = '0;
    m_sec = 0;
    m_lc = 0;
    fsm_st = 3'b000;
    #3;
    chk("rst_light_cnt", bus.light_cnt, 0);
    chk("rst_lc_last", bus.light_cnt_last, 1);
    chk("rst_pre_last", bus.second_cnt_pre_last, 0);
    chk("rst_sec_last", bus.second_cnt_last, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    n_pre = 0;
    n_lcl = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 3'd2);
      n_pre += int'(o_pre);
      if (i >= 4 && i < 16) n_lcl += int'(o_lcl);
    end
    chk("t1_pre_count", n_pre, 5);
    chk("t1_lcl_per_12", n_lcl, 4);

    for (int i = 0; i < 40 && !(m_lc == 0 && m_sec == CPS - 1); i++) step(1'b1, 1'b0, 3'd2);
    chk("t2_reach_sec", bus.sec_cnt, CPS - 1);
    step(1'b1, 1'b0, 3'd5);
    chk("t2_reload", bus.light_cnt, 5);

    for (int i = 0; i < 8 && m_sec != 1; i++) step(1'b1, 1'b0, 3'd5);
    hold_lc = m_lc;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd5);
    chk("t3_hold_sec", bus.sec_cnt, 1);
    chk("t3_hold_lc", bus.light_cnt, hold_lc);
    step(1'b1, 1'b0, 3'd5);
    chk("t3_no_early_pre", o_pre, 0);
    step(1'b1, 1'b0, 3'd5);
    chk("t3_pre_after_1", o_pre, 1);

    for (int i = 0; i < 40 && !(m_lc == 3 && m_sec == 2); i++) step(1'b1, 1'b0, 3'd5);
    chk("t4_reach_lc", bus.light_cnt, 3);
    step(1'b1, 1'b1, 3'd5);
    chk("t4_no_pre_in_clr", o_pre, 0);
    chk("t4_sec_cleared", bus.sec_cnt, 0);
    chk("t4_lc_cleared", bus.light_cnt, 0);
    chk("t4_lcl_high", bus.light_cnt_last, 1);
    step(1'b1, 1'b0, 3'd5);
    chk("t4_no_pre_after", o_pre, 0);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 3'($urandom));

    for (int i = 0; i < 40 && m_lc == 0; i++) step(1'b1, 1'b0, 3'd3);
    chk("t5_pre_lc_nonzero", bus.light_cnt != 0, 1);
    bus.en = 1'b1;
    bus.clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_lc", bus.light_cnt, 0);
    chk("t5_async_lcl", bus.light_cnt_last, 1);
    chk("t5_async_pre", bus.second_cnt_pre_last, 0);
    chk("t5_async_last", bus.second_cnt_last, 0);
    chk("t5_async_sec", bus.sec_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_sec = 0;
    m_lc = 0;
    fsm_st = 3'b000;

    run_st = fsm_st;
    run_len = 0;
    for (int i = 0; i < 400 && q_len.size() < 7; i++) begin
      step(1'b1, 1'b0, fsm_init(fsm_st));
      run_len++;
      if (fsm_st != run_st) begin
        q_st.push_back(run_st);
        q_len.push_back(run_len);
        run_st = fsm_st;
        run_len = 0;
      end
    end
    chk("t6_runs_seen", q_len.size(), 7);
    for (int i = 0; i < 6; i++)
      if (q_len.size() > i + 1) begin
        chk("t6_state", q_st[i+1], int'(st_exp[i]));
        chk("t6_len", q_len[i+1], len_exp[i]);
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
